// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared Ethernet framing constants and the TX reader state encoding.
// Used by frame_tx_reader and eth_crc32_d8, and intended for the future
// RX checker as well.
//   PREAMBLE_BYTE / SFD_BYTE : start-of-frame delimiter bytes
//   PREAMBLE_LEN             : number of 0x55 bytes ahead of the SFD
//   CRC32_POLY / CRC32_INIT  : reflected IEEE 802.3 CRC32 definition
//   BYTE_CNT_W               : width of the per-frame DATA+PAD byte counter
//   eth_state_e              : TX reader sequencing states
// -----------------------------------------------------------------------------
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PREAMBLE_LEN  = 7;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  localparam int          BYTE_CNT_W    = 11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SFD  = 3'd2,
    DATA = 3'd3,
    PAD  = 3'd4,
    FCS  = 3'd5,
    IFG  = 3'd6
  } eth_state_e;

endpackage

// File: rtl/eth_crc32_d8.sv
// -----------------------------------------------------------------------------
// eth_crc32_d8
// Combinational one-byte step of the reflected CRC32 (poly 0xEDB88320).
// The data byte is consumed LSB first. The register is not inverted here:
// callers seed it with CRC32_INIT and complement the final value themselves.
// Ports:
//   crc_in  [31:0] : running CRC before this byte
//   d       [7:0]  : data byte
//   crc_out [31:0] : running CRC after this byte
// -----------------------------------------------------------------------------
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  // stage[k] holds the CRC after k data bits have been shifted in.
  logic [31:0] stage [0:8];

  assign stage[0] = crc_in;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      // The feedback bit is the outgoing LSB xor the incoming data bit.
      logic fb;
      assign fb            = stage[gi][0] ^ d[gi];
      assign stage[gi + 1] = fb ? ((stage[gi] >> 1) ^ CRC32_POLY)
                                : (stage[gi] >> 1);
    end
  endgenerate

  assign crc_out = stage[8];

endmodule

// File: rtl/frame_tx_reader.sv
// -----------------------------------------------------------------------------
// frame_tx_reader
// Read-side consumer of the frame FIFO. It waits until a complete frame is
// stored. It then emits the frame as an Ethernet byte stream:
//   preamble (7 x 0x55), SFD (0xD5), payload, zero pad up to MIN_FRAME,
//   CRC32 FCS (LSB first), and finally an inter-frame gap.
// Ports:
//   clk, rst           : read clock, synchronous active-high reset
//   fifo_do/fifo_eod   : FWFT head byte and its end-of-frame flag
//   fifo_empty         : FIFO empty flag
//   fifo_frame_exist   : at least one complete frame stored
//   fifo_re            : pop strobe (combinational)
//   tx_data/tx_valid   : registered output byte stream
//   tx_ready           : serializer accepts on tx_valid & tx_ready
//   tx_busy            : reader is not idle
//   underrun           : FIFO ran dry mid-payload (registered pulse)
//   frames_sent        : wrapping count of completed frames
// -----------------------------------------------------------------------------
module frame_tx_reader
  import eth_pkg::*;
#(
  parameter int MIN_FRAME  = 60,
  parameter int IFG_CYCLES = 12,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       fifo_do,
  input  logic             fifo_eod,
  input  logic             fifo_empty,
  input  logic             fifo_frame_exist,
  output logic             fifo_re,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_busy,
  output logic             underrun,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int IFG_W = $clog2(IFG_CYCLES + 1);
  // The IFG counter starts in the cycle after the last FCS byte is accepted.
  // The IDLE evaluation cycle also has tx_valid low, so it is one of the
  // IFG_CYCLES gap cycles. That leaves IFG_CYCLES-1 counting cycles.
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 2);

  eth_state_e             state_reg;
  logic [7:0]             tx_data_reg;
  logic                   tx_valid_reg;
  logic                   underrun_reg;
  logic [CNT_W-1:0]       frames_sent_reg;
  logic [31:0]            crc_reg;
  logic [BYTE_CNT_W-1:0]  byte_cnt_reg;
  logic [2:0]             pre_cnt_reg;
  logic [1:0]             fcs_idx_reg;
  logic [IFG_W-1:0]       ifg_cnt_reg;
  logic                   ifg_drain_reg;

  logic                   adv;
  logic                   data_take;
  logic [7:0]             crc_d;
  logic [31:0]            crc_next;
  logic [31:0]            fcs_word;
  logic [7:0]             fcs_byte;
  logic [BYTE_CNT_W-1:0]  byte_cnt_inc;
  logic                   pad_after_data;
  logic                   pad_done;

  // The output register may be (re)loaded when empty or being consumed.
  assign adv       = !tx_valid_reg || tx_ready;
  assign data_take = (state_reg == DATA) && adv && !fifo_empty;

  // Gated by rst so that the FIFO is left untouched during a reset cycle.
  assign fifo_re   = data_take && !rst;

  // PAD bytes feed zeros into the CRC. DATA bytes feed the FIFO head.
  assign crc_d     = (state_reg == PAD) ? 8'h00 : fifo_do;

  eth_crc32_d8 u_crc (
    .crc_in  (crc_reg),
    .d       (crc_d),
    .crc_out (crc_next)
  );

  always_comb begin
    fcs_word = ~crc_reg;
    fcs_byte = 8'(fcs_word >> {fcs_idx_reg, 3'b000});
  end

  // Saturating increment. Frames longer than 2047 bytes are not truncated;
  // only the length bookkeeping stops counting.
  assign byte_cnt_inc   = (byte_cnt_reg == {BYTE_CNT_W{1'b1}}) ? byte_cnt_reg
                                                               : byte_cnt_reg + 1'b1;
  assign pad_after_data = (int'(byte_cnt_reg) + 1) < MIN_FRAME;
  assign pad_done       = (int'(byte_cnt_reg) + 1) >= MIN_FRAME;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      tx_data_reg     <= 8'h00;
      tx_valid_reg    <= 1'b0;
      underrun_reg    <= 1'b0;
      frames_sent_reg <= '0;
      crc_reg         <= CRC32_INIT;
      byte_cnt_reg    <= '0;
      pre_cnt_reg     <= '0;
      fcs_idx_reg     <= '0;
      ifg_cnt_reg     <= '0;
      ifg_drain_reg   <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          // The first preamble byte is loaded on the way out of IDLE, so it
          // becomes valid in the following cycle.
          if (fifo_frame_exist && adv) begin
            tx_data_reg  <= PREAMBLE_BYTE;
            tx_valid_reg <= 1'b1;
            pre_cnt_reg  <= 3'd1;
            state_reg    <= PRE;
          end
        end

        PRE: begin
          if (adv) begin
            tx_data_reg  <= PREAMBLE_BYTE;
            tx_valid_reg <= 1'b1;
            pre_cnt_reg  <= pre_cnt_reg + 3'd1;
            if (pre_cnt_reg == 3'(PREAMBLE_LEN - 1)) begin
              state_reg <= SFD;
            end
          end
        end

        SFD: begin
          if (adv) begin
            tx_data_reg  <= SFD_BYTE;
            tx_valid_reg <= 1'b1;
            byte_cnt_reg <= '0;
            crc_reg      <= CRC32_INIT;
            state_reg    <= DATA;
          end
        end

        DATA: begin
          if (fifo_empty) begin
            underrun_reg <= 1'b1;
          end
          if (adv) begin
            if (!fifo_empty) begin
              tx_data_reg  <= fifo_do;
              tx_valid_reg <= 1'b1;
              byte_cnt_reg <= byte_cnt_inc;
              crc_reg      <= crc_next;
              if (fifo_eod) begin
                fcs_idx_reg <= 2'd0;
                state_reg   <= pad_after_data ? PAD : FCS;
              end
            end else begin
              // A bubble rather than a stale byte while the FIFO is dry.
              tx_valid_reg <= 1'b0;
            end
          end
        end

        PAD: begin
          if (adv) begin
            tx_data_reg  <= 8'h00;
            tx_valid_reg <= 1'b1;
            byte_cnt_reg <= byte_cnt_inc;
            crc_reg      <= crc_next;
            if (pad_done) begin
              state_reg <= FCS;
            end
          end
        end

        FCS: begin
          if (adv) begin
            tx_data_reg  <= fcs_byte;
            tx_valid_reg <= 1'b1;
            fcs_idx_reg  <= fcs_idx_reg + 2'd1;
            if (fcs_idx_reg == 2'd3) begin
              frames_sent_reg <= frames_sent_reg + 1'b1;
              ifg_drain_reg   <= 1'b1;
              state_reg       <= IFG;
            end
          end
        end

        IFG: begin
          if (ifg_drain_reg) begin
            // Hold the last FCS byte until the serializer takes it. The gap
            // is measured from that acceptance.
            if (adv) begin
              tx_valid_reg  <= 1'b0;
              ifg_drain_reg <= 1'b0;
              ifg_cnt_reg   <= '0;
            end
          end else if (ifg_cnt_reg == IFG_LAST) begin
            state_reg <= IDLE;
          end else begin
            ifg_cnt_reg <= ifg_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign tx_data     = tx_data_reg;
  assign tx_valid    = tx_valid_reg;
  assign underrun    = underrun_reg;
  assign frames_sent = frames_sent_reg;
  assign tx_busy     = (state_reg != IDLE);

endmodule
